// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU owning the accumulator and the {N,V,C,Z} flags.
//
// Sixteen operations are issued over a valid/ready handshake. All of them
// complete in one cycle except MUL, which runs a WIDTH-iteration shift-add
// multiplier, and HLT, which parks the block until reset.
//
// Ports
//   i_clk      clock, all state updates on the rising edge
//   i_rst      synchronous active-high reset
//   i_valid    operation request
//   i_op_code  4-bit operation code
//   i_alu_in   operand (memory/bus data)
//   o_ready    block can accept an operation this cycle
//   o_done     one-cycle pulse: ACC/flags hold the last accepted result
//   o_alu_out  accumulator register
//   o_flags    {N,V,C,Z} flag register
//   o_halted   sticky halt indicator
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [3:0]       i_op_code,
   input  logic [WIDTH-1:0] i_alu_in,
   output logic             o_ready,
   output logic             o_done,
   output logic [WIDTH-1:0] o_alu_out,
   output logic [3:0]       o_flags,
   output logic             o_halted
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDO = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_STO = 4'h3;
   localparam logic [3:0] OP_PRE = 4'h4;
   localparam logic [3:0] OP_ADD = 4'h5;
   localparam logic [3:0] OP_LDM = 4'h6;
   localparam logic [3:0] OP_HLT = 4'h7;
   localparam logic [3:0] OP_SUB = 4'h8;
   localparam logic [3:0] OP_AND = 4'h9;
   localparam logic [3:0] OP_OR  = 4'hA;
   localparam logic [3:0] OP_XOR = 4'hB;
   localparam logic [3:0] OP_SHL = 4'hC;
   localparam logic [3:0] OP_SHR = 4'hD;
   localparam logic [3:0] OP_MUL = 4'hE;
   localparam logic [3:0] OP_CMP = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t               state_r,  state_nxt_s;
   logic [WIDTH-1:0]     acc_r,    acc_nxt_s;
   logic [3:0]           flags_r,  flags_nxt_s;
   logic                 done_r,   done_nxt_s;
   logic                 ready_r,  ready_nxt_s;
   logic                 halted_r, halted_nxt_s;
   logic [2*WIDTH-1:0]   mcand_r,  mcand_nxt_s;
   logic [WIDTH-1:0]     mplier_r, mplier_nxt_s;
   logic [2*WIDTH-1:0]   prod_r,   prod_nxt_s;
   logic [CNT_W-1:0]     cnt_r,    cnt_nxt_s;

   logic [WIDTH:0]       add_full_s;
   logic                 add_v_s;
   logic [WIDTH-1:0]     diff_s;
   logic                 borrow_s;
   logic                 sub_v_s;
   logic [2*WIDTH-1:0]   partial_s;

   // Pack a result plus carry/overflow into {N,V,C,Z}.
   function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                             input logic c, input logic v);
      return {res[WIDTH-1], v, c, (res == {WIDTH{1'b0}})};
   endfunction

   // Shared arithmetic: adder, subtractor and one multiplier iteration.
   always_comb begin
      add_full_s = {1'b0, acc_r} + {1'b0, i_alu_in};
      // Overflow when operands share a sign that the sum does not.
      add_v_s    = (acc_r[WIDTH-1] == i_alu_in[WIDTH-1]) &&
                   (add_full_s[WIDTH-1] != acc_r[WIDTH-1]);
      diff_s     = acc_r - i_alu_in;
      borrow_s   = (acc_r < i_alu_in);
      // Overflow when operand signs differ and the difference flips ACC's sign.
      sub_v_s    = (acc_r[WIDTH-1] != i_alu_in[WIDTH-1]) &&
                   (diff_s[WIDTH-1] != acc_r[WIDTH-1]);
      partial_s  = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_nxt_s  = state_r;
      acc_nxt_s    = acc_r;
      flags_nxt_s  = flags_r;
      done_nxt_s   = 1'b0;
      mcand_nxt_s  = mcand_r;
      mplier_nxt_s = mplier_r;
      prod_nxt_s   = prod_r;
      cnt_nxt_s    = cnt_r;

      case (state_r)
         ST_IDLE: begin
            if (i_valid && ready_r) begin
               done_nxt_s = 1'b1;
               case (i_op_code)
                  OP_NOP, OP_STO, OP_LDM: begin
                     acc_nxt_s = acc_r;
                  end
                  OP_LDO, OP_LDA, OP_PRE: begin
                     acc_nxt_s   = i_alu_in;
                     flags_nxt_s = make_flags(i_alu_in, flags_r[1], flags_r[2]);
                  end
                  OP_ADD: begin
                     acc_nxt_s   = add_full_s[WIDTH-1:0];
                     flags_nxt_s = make_flags(add_full_s[WIDTH-1:0],
                                              add_full_s[WIDTH], add_v_s);
                  end
                  OP_HLT: begin
                     state_nxt_s = ST_HALT;
                  end
                  OP_SUB: begin
                     acc_nxt_s   = diff_s;
                     flags_nxt_s = make_flags(diff_s, borrow_s, sub_v_s);
                  end
                  OP_AND: begin
                     acc_nxt_s   = acc_r & i_alu_in;
                     flags_nxt_s = make_flags(acc_r & i_alu_in, 1'b0, 1'b0);
                  end
                  OP_OR: begin
                     acc_nxt_s   = acc_r | i_alu_in;
                     flags_nxt_s = make_flags(acc_r | i_alu_in, 1'b0, 1'b0);
                  end
                  OP_XOR: begin
                     acc_nxt_s   = acc_r ^ i_alu_in;
                     flags_nxt_s = make_flags(acc_r ^ i_alu_in, 1'b0, 1'b0);
                  end
                  OP_SHL: begin
                     acc_nxt_s   = {acc_r[WIDTH-2:0], 1'b0};
                     flags_nxt_s = make_flags({acc_r[WIDTH-2:0], 1'b0},
                                              acc_r[WIDTH-1], 1'b0);
                  end
                  OP_SHR: begin
                     acc_nxt_s   = {1'b0, acc_r[WIDTH-1:1]};
                     flags_nxt_s = make_flags({1'b0, acc_r[WIDTH-1:1]},
                                              acc_r[0], 1'b0);
                  end
                  OP_MUL: begin
                     // Result pulse comes from the final iteration instead.
                     done_nxt_s   = 1'b0;
                     mcand_nxt_s  = {{WIDTH{1'b0}}, acc_r};
                     mplier_nxt_s = i_alu_in;
                     prod_nxt_s   = {(2*WIDTH){1'b0}};
                     cnt_nxt_s    = {CNT_W{1'b0}};
                     state_nxt_s  = ST_MUL;
                  end
                  OP_CMP: begin
                     flags_nxt_s = make_flags(diff_s, borrow_s, sub_v_s);
                  end
                  default: begin
                     acc_nxt_s = acc_r;
                  end
               endcase
            end else begin
               done_nxt_s = 1'b0;
            end
         end
         ST_MUL: begin
            prod_nxt_s   = partial_s;
            mcand_nxt_s  = mcand_r << 1;
            mplier_nxt_s = mplier_r >> 1;
            cnt_nxt_s    = cnt_r + CNT_W'(1);
            // The WIDTH-th iteration writes back straight from the adder.
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
               acc_nxt_s   = partial_s[WIDTH-1:0];
               flags_nxt_s = make_flags(partial_s[WIDTH-1:0],
                                        |partial_s[2*WIDTH-1:WIDTH], 1'b0);
               done_nxt_s  = 1'b1;
               cnt_nxt_s   = {CNT_W{1'b0}};
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_MUL;
            end
         end
         ST_HALT: begin
            state_nxt_s = ST_HALT;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      ready_nxt_s  = (state_nxt_s == ST_IDLE);
      halted_nxt_s = (state_nxt_s == ST_HALT);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r  <= ST_IDLE;
         acc_r    <= {WIDTH{1'b0}};
         flags_r  <= 4'b0000;
         done_r   <= 1'b0;
         ready_r  <= 1'b1;
         halted_r <= 1'b0;
         mcand_r  <= {(2*WIDTH){1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         prod_r   <= {(2*WIDTH){1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         acc_r    <= acc_nxt_s;
         flags_r  <= flags_nxt_s;
         done_r   <= done_nxt_s;
         ready_r  <= ready_nxt_s;
         halted_r <= halted_nxt_s;
         mcand_r  <= mcand_nxt_s;
         mplier_r <= mplier_nxt_s;
         prod_r   <= prod_nxt_s;
         cnt_r    <= cnt_nxt_s;
      end
   end

   assign o_ready   = ready_r;
   assign o_done    = done_r;
   assign o_alu_out = acc_r;
   assign o_flags   = flags_r;
   assign o_halted  = halted_r;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the CPU's combinational 8-bit ALU. It owns the accumulator and a flag register, and extends the opcode space from 3 to 4 bits: the eight legacy operations keep their codes, and eight new ones add subtract, logic, shifts, compare and a multi-cycle multiply. The CPU controller issues operations through a valid/ready handshake and reads the accumulator and flags from registered outputs.

## Interface
- WIDTH, 8, datapath and accumulator width in bits (≥2).
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  operation request.
- i_op_code  input  4  operation code.
- i_alu_in  input  WIDTH  operand (memory/bus data).
- o_ready  output  1  block can accept an operation this cycle.
- o_done  output  1  one-cycle pulse: the accumulator and flags now hold the result of the last accepted operation.
- o_alu_out  output  WIDTH  accumulator register.
- o_flags  output  4  {N,V,C,Z} flag register.
- o_halted  output  1  sticky halt indicator.

## Operation
- **Accept rule.** An operation is accepted on a rising edge where i_valid=1 and o_ready=1. i_op_code and i_alu_in are sampled only at accept. Requests made while o_ready=0 are ignored and are not queued.
- **Opcode map.** Write ACC for the accumulator and IN for i_alu_in.
  - 0 NOP, 3 STO, 6 LDM: ACC and flags unchanged.
  - 1 LDO, 2 LDA, 4 PRE: ACC=IN; Z and N updated; C and V unchanged.
  - 5 ADD: ACC=ACC+IN; C=carry out; V=signed overflow.
  - 7 HLT: ACC and flags unchanged; o_halted set.
  - 8 SUB: ACC=ACC−IN; C=borrow (1 when ACC<IN, unsigned); V=signed overflow.
  - 9 AND, A OR, B XOR: bitwise ACC op IN; C=0, V=0.
  - C SHL: ACC=ACC<<1; C=old ACC[WIDTH-1]; V=0. IN is ignored.
  - D SHR (logical): ACC=ACC>>1; C=old ACC[0]; V=0. IN is ignored.
  - E MUL (unsigned, multi-cycle): ACC=low WIDTH bits of ACC×IN; C=1 when the upper WIDTH bits of the product are non-zero; V=0.
  - F CMP: flags set exactly as for SUB; ACC unchanged.
- **Flag rules.** Every op that updates flags sets Z=(result==0) and N=result[WIDTH-1]. For CMP, "result" is the difference. All arithmetic wraps modulo 2^WIDTH.
- **State machine.**
  - IDLE: o_ready=1. Accepting MUL moves to MUL. Accepting HLT moves to HALT. Any other op completes in IDLE.
  - MUL: o_ready=0. Shift-add multiplier with a multiplicand register, a multiplier register, a 2·WIDTH product register and an iteration counter. The multiplicand is ACC captured at accept. Each edge adds the shifted multiplicand when the multiplier LSB is 1, then shifts. After exactly WIDTH iterations: write ACC and flags, then return to IDLE.
  - HALT: o_ready=0, o_halted=1. Only i_rst leaves this state.
- **Reset.** While i_rst=1, a rising edge forces:
  - ACC=0, flags=0, o_done=0, o_halted=0, o_ready=1, state IDLE, counter=0.
  - Reset overrides everything, including an in-progress MUL. The MUL is aborted with no partial write, and o_done does not pulse.

## Timing
- **Single-cycle ops.** Accept at edge k. ACC and flags are updated at edge k, and o_done=1 for the cycle following edge k. o_ready stays 1, so back-to-back ops are accepted every cycle with o_done held high continuously. NOP/STO/LDM/HLT also pulse o_done.
- **MUL.** Accept at edge k. o_ready=0 from edge k until edge k+WIDTH. ACC, flags and o_done=1 are all updated at edge k+WIDTH. The next accept is possible at edge k+WIDTH+1. Total latency is WIDTH+1 edges from accept to the first cycle o_ready is high again.
- **Stable operands.** o_alu_out and o_flags are registered and stay stable between result writes. ACC is not visibly modified during MUL.
- **HLT.** o_halted=1 and o_ready=0 from the cycle after the accept edge.

## Test plan
- **Reset values.** Assert i_rst for 2 cycles → o_alu_out=0, o_flags=0, o_ready=1, o_done=0, o_halted=0.
- **LDA, ADD, SUB, CMP (WIDTH=8).**
  - LDA 0xF0 → ACC=0xF0, N=1.
  - ADD 0x20 → ACC=0x10, C=1, V=0, Z=0; o_done pulses one cycle each.
  - SUB 0x10 → ACC=0x00, Z=1, C=0.
  - CMP 0x01 → ACC=0x00, C=1, N=1.
- **MUL within range.** LDA 13, then MUL 11 → o_ready low for 8 cycles, then ACC=0x8F, N=1, C=0. o_done pulses exactly once, 8 edges after accept.
- **MUL overflow, with a request ignored mid-op.** LDA 0x20, then MUL 0x10 → ACC=0x00, Z=1, C=1. An ADD presented with i_valid held high during MUL is not accepted; ACC is unchanged after MUL completes until the ADD is re-presented while o_ready=1.
- **HLT, then reset mid-MUL.**
  - HLT → o_halted=1. ADD requests are ignored and ACC is held. i_rst then clears the halt.
  - Start MUL, assert i_rst at iteration 4 → ACC=0, no o_done pulse, o_ready=1 after the reset edge.
- **Shifts and logic.**
  - LDA 0x81, SHL → ACC=0x02, C=1.
  - SHR → ACC=0x01, C=0.
  - XOR 0x01 → ACC=0x00, Z=1, C=0, V=0.
